kb_scan_sequencer: RTL
======================

# kb_scan_sequencer

Controller that sequences raw PS/2 set-2 scan-code bytes into the combinational scan-to-ASCII lookup and queues the results for a consumer. It decodes break (F0) and extended (E0) prefixes, owns the shift and caps-lock modifier state that configures the lookup, and buffers translated characters in a small FIFO behind a valid/ready handshake. It sits between the PS/2 byte receiver and the text consumer.

## Interface
- FIFO_DEPTH, 8, character FIFO entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- sc_in  in  8  scan-code byte from PS/2 receiver
- sc_valid  in  1  one-cycle strobe qualifying sc_in
- lut_sc  out  8  registered scan code driven to lookup
- lut_shift  out  1  shift modifier to lookup (lshift | rshift)
- lut_caps  out  1  caps-lock modifier to lookup
- lut_ascii  in  8  lookup result for lut_sc/lut_shift/lut_caps; 0x00 = no character
- ascii_data  out  8  FIFO head (first-word fall-through)
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts head when high with ascii_valid
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a character was discarded on full FIFO
- sc_drop  out  1  one-cycle pulse: sc_valid arrived in LOOKUP and was discarded

## Operation
- FSM states: IDLE, BREAK, EXT, EXT_BREAK, LOOKUP. Reset → IDLE.
- IDLE on sc_valid: F0→BREAK; E0→EXT; 12→lshift=1; 59→rshift=1; 58→if !caps_held {caps toggles; caps_held=1}; any other → lut_sc<=sc_in, held_sc<=sc_in, →LOOKUP.
- BREAK on sc_valid: 12→lshift=0; 59→rshift=0; 58→caps_held=0; sc_in==held_sc→held_sc=0x00; other codes ignored; →IDLE. No output on any break.
- EXT on sc_valid: F0→EXT_BREAK; any other byte ignored (extended keys not translated), →IDLE.
- EXT_BREAK on sc_valid: byte ignored, →IDLE.
- LOOKUP (one cycle, unconditional →IDLE): if lut_ascii!=0 push into FIFO; else nothing. sc_valid in LOOKUP → byte discarded, sc_drop pulses.
- Modifier state changes only from sc_valid events; lut_shift/lut_caps are registered.
- FIFO push on full: character discarded, overflow set, held until reset.
- Simultaneous push and pop: both take effect; on full, pop frees the slot and push is accepted (count unchanged).
- Pop only when ascii_valid && ascii_ready; ascii_ready while empty is ignored.
- Reset mid-operation: FSM→IDLE, modifiers, caps_held, held_sc, FIFO pointers, overflow cleared; partial prefixes lost.

## Timing
- Reset values: lut_sc=0x00, lut_shift=0, lut_caps=0, ascii_data=0x00, ascii_valid=0, fifo_count=0, overflow=0, sc_drop=0.
- Make code strobed in cycle N: lut_sc valid N+1 (LOOKUP), push at end of N+1, ascii_valid high in N+2 if FIFO was empty.
- Modifier byte in cycle N: lut_shift/lut_caps update in N+1.
- Pop in cycle N: ascii_data shows next entry (or ascii_valid=0) in N+1.
- sc_valid strobes must be ≥2 cycles apart; PS/2 byte spacing guarantees this in the system.

## Configuration
- KB_SUPPRESS_REPEAT_EN defined: in IDLE, a make code equal to held_sc (keyboard typematic repeat) updates nothing and does not enter LOOKUP; one character per physical press.
- Undefined: every make code, including repeats of held_sc, goes through LOOKUP and pushes a character.

## Structure
- Shared package kb_pkg: scan-code constants SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58; FSM state encoding.
- One sub-module: kb_ascii_fifo (parameterised FWFT FIFO, push/pop/full/empty/count). FSM and modifier logic stay in the top.

## Test plan
- 1C with ascii_ready=1 → ascii_valid two cycles later, ascii_data=0x61 ('a'); then 1C again → second 0x61 (macro undefined) / none (macro defined).
- 12, 1C, F0 12, 1C → outputs 0x41 then 0x61; lut_shift high only between 12 and F0 12.
- 58, F0 58, 1C → 0x41; 58, 58, F0 58 → caps toggles once only; 58, F0 58 again → caps cleared, 1C → 0x61.
- F0 1C and E0 75, E0 F0 75 → no output, FSM back in IDLE, modifiers unchanged.
- ascii_ready=0, nine distinct makes 1C,32,21,23,24,2B,34,33,43 → fifo_count=8, overflow=1; drain yields 0x61…0x68 in order, 0x69 lost.
- Full FIFO with ascii_ready=1 and push in same cycle → count stays 8, overflow stays 0; reset asserted mid-sequence after F0 → next 1C produces 0x61.

Source files
------------

// File: rtl/kb_pkg.sv
// ---------------------------------------------------------------------------
// kb_pkg
// Shared definitions for the PS/2 keyboard scan sequencer: the set-2
// scan-code bytes the sequencer treats specially, and the encoding of the
// prefix-decoding state machine.
// ---------------------------------------------------------------------------
package kb_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    // Modifier keys handled inside the sequencer
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Prefix decoder states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BREAK     = 3'd1,
        EXT       = 3'd2,
        EXT_BREAK = 3'd3,
        LOOKUP    = 3'd4
    } kb_state_t;

endpackage

// File: rtl/kb_ascii_fifo.sv
// ---------------------------------------------------------------------------
// kb_ascii_fifo
// First-word fall-through FIFO for translated characters. The head entry
// is visible on pop_data whenever the FIFO is not empty. When it is empty,
// pop_data reads 0x00.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset (clears pointers)
//   push       write push_data this cycle (ignored when full unless popping)
//   push_data  character to write
//   pop        remove head this cycle (ignored when empty)
//   pop_data   current head entry
//   full       all DEPTH entries occupied
//   empty      no entries
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module kb_ascii_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        pop_ok;
    logic        push_ok;

    // The pointers carry one extra wrap bit so that full and empty can be
    // told apart when the index bits are equal.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The storage array is not reset. Its contents are qualified by the
    // pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// kb_scan_sequencer
// Sequences raw PS/2 set-2 scan-code bytes into an external combinational
// scan-to-ASCII lookup and queues the non-zero results in a FIFO.
//
// Processing steps:
//   - Decodes the break (F0) and extended (E0) prefixes.
//   - Tracks the left/right shift and caps-lock modifier state.
//   - Keeps the last make code (held_sc) so that a release can clear it.
//
// Build option:
//   KB_SUPPRESS_REPEAT_EN  When defined, a make code in IDLE that equals
//                          held_sc (a typematic repeat) is ignored. Each
//                          physical press then produces one character.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   sc_in         scan-code byte from the PS/2 receiver
//   sc_valid      one-cycle strobe qualifying sc_in
//   lut_sc        registered scan code presented to the lookup
//   lut_shift     shift modifier to the lookup (lshift | rshift)
//   lut_caps      caps-lock modifier to the lookup
//   lut_ascii     lookup result; 0x00 means no character
//   ascii_data    FIFO head (first-word fall-through)
//   ascii_valid   FIFO non-empty
//   ascii_ready   consumer accepts the head when high with ascii_valid
//   fifo_count    current FIFO occupancy
//   overflow      sticky: a character was dropped on a full FIFO
//   sc_drop       pulse: a byte arrived during LOOKUP and was discarded
// ---------------------------------------------------------------------------
module kb_scan_sequencer
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    sc_in,
    input  logic                          sc_valid,
    output logic [7:0]                    lut_sc,
    output logic                          lut_shift,
    output logic                          lut_caps,
    input  logic [7:0]                    lut_ascii,
    output logic [7:0]                    ascii_data,
    output logic                          ascii_valid,
    input  logic                          ascii_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          sc_drop
);

    kb_state_t   state_q, state_d;
    logic [7:0]  lut_sc_q, lut_sc_d;
    logic [7:0]  held_sc_q, held_sc_d;
    logic        lshift_q, lshift_d;
    logic        rshift_q, rshift_d;
    logic        caps_q, caps_d;
    logic        caps_held_q, caps_held_d;
    logic        overflow_q, overflow_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign lut_sc      = lut_sc_q;
    assign lut_shift   = lshift_q | rshift_q;
    assign lut_caps    = caps_q;
    assign overflow    = overflow_q;
    assign ascii_valid = !fifo_empty;

    // The lookup result is consumed in the single LOOKUP cycle.
    assign fifo_push = (state_q == LOOKUP) && (lut_ascii != 8'h00);
    assign fifo_pop  = ascii_valid && ascii_ready;
    assign sc_drop   = (state_q == LOOKUP) && sc_valid;

    // Next-state logic for prefix decoding and modifier tracking. Every
    // change is triggered by an sc_valid byte, except the LOOKUP -> IDLE
    // return.
    always_comb begin
        state_d     = state_q;
        lut_sc_d    = lut_sc_q;
        held_sc_d   = held_sc_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;

        case (state_q)
            IDLE: begin
                if (sc_valid) begin
                    if (sc_in == SC_BREAK) begin
                        state_d = BREAK;
                    end else if (sc_in == SC_EXT) begin
                        state_d = EXT;
                    end else if (sc_in == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (sc_in == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (sc_in == SC_CAPS) begin
                        // Caps toggles once per press. Typematic repeats
                        // are blocked until the key is released.
                        if (!caps_held_q) begin
                            caps_d      = !caps_q;
                            caps_held_d = 1'b1;
                        end
                    end else begin
`ifdef KB_SUPPRESS_REPEAT_EN
                        if (sc_in != held_sc_q) begin
                            lut_sc_d  = sc_in;
                            held_sc_d = sc_in;
                            state_d   = LOOKUP;
                        end
`else
                        lut_sc_d  = sc_in;
                        held_sc_d = sc_in;
                        state_d   = LOOKUP;
`endif
                    end
                end
            end
            BREAK: begin
                if (sc_valid) begin
                    if (sc_in == SC_LSHIFT) lshift_d    = 1'b0;
                    if (sc_in == SC_RSHIFT) rshift_d    = 1'b0;
                    if (sc_in == SC_CAPS)   caps_held_d = 1'b0;
                    if (sc_in == held_sc_q) held_sc_d   = 8'h00;
                    state_d = IDLE;
                end
            end
            EXT: begin
                if (sc_valid) begin
                    state_d = (sc_in == SC_BREAK) ? EXT_BREAK : IDLE;
                end
            end
            EXT_BREAK: begin
                if (sc_valid) state_d = IDLE;
            end
            LOOKUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The overflow flag is sticky. It is set only when a push finds the
    // FIFO full and no pop is freeing a slot in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lut_sc_q    <= 8'h00;
            held_sc_q   <= 8'h00;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lut_sc_q    <= lut_sc_d;
            held_sc_q   <= held_sc_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            overflow_q  <= overflow_d;
        end
    end

    kb_ascii_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (lut_ascii),
        .pop       (fifo_pop),
        .pop_data  (ascii_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
